alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
Controller that shares one 4-bit add/sub ALU (op 0 = add, op 1 = subtract) between two independent requesters. Arbitrates requests (round-robin or fixed priority) and captures the winner's operands and op into registers driving the ALU. Registers the 4-bit result and returns it with a per-requester done pulse. Sits between client FSMs and the combinational ALU datapath.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties
WIDTH, 4, operand/result width; fixed to 4 to match the ALU

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request; held high until gnt0 seen
op0  input  1  requester 0 op: 0 add, 1 subtract
a0  input  4  requester 0 operand A
b0  input  4  requester 0 operand B
req1  input  1  requester 1 request
op1  input  1  requester 1 op
a1  input  4  requester 1 operand A
b1  input  4  requester 1 operand B
gnt0  output  1  one-cycle pulse: requester 0 operands captured
gnt1  output  1  one-cycle pulse: requester 1 operands captured
done0  output  1  one-cycle pulse: result valid for requester 0
done1  output  1  one-cycle pulse: result valid for requester 1
result  output  4  registered ALU result; holds until next done
zero  output  1  registered; 1 when result == 0, updated with result
busy  output  1  high in EXEC and DONE states

Behaviour:
- One clock, clk; reset is asynchronous and active-high (rst).
- Reset (async, any state): state=IDLE; gnt0/1, done0/1, busy=0; result=0; zero=1; captured op/operands=0; rr pointer=1 (requester 0 wins first contest).
- States: IDLE, EXEC, DONE. All outputs registered.
- IDLE: at edge, if any req high: pick winner, capture op/a/b of winner, set gnt of winner=1, state->EXEC. Else stay IDLE, outputs 0.
- Arbitration: only req0 -> 0; only req1 -> 1; both -> FIXED_PRIORITY=1: 0; else the requester not equal to rr pointer; rr pointer <= winner on each grant.
- EXEC (1 cycle): gnt pulse visible; ALU sees captured operands. At edge: result <= ALU output, zero <= (ALU output==0), done of winner=1, gnt=0, state->DONE.
- DONE (1 cycle): done pulse visible with result. At edge: done=0, state->IDLE.
- Latency: grant edge to done-visible = 1 cycle; one op per 3 cycles max throughput; grants only issued from IDLE.
- Arithmetic: mod 16; add = a+b, sub = a-b (two's complement wrap); no carry/borrow output.
- Requests not sampled in EXEC/DONE; a req dropped before being granted has no effect; req still high in IDLE after its done counts as a new request.
- Operand/op changes after grant do not affect in-flight result.
- Reset mid-operation: in-flight op discarded, no done issued, result cleared to 0.
- Exactly one of gnt0/gnt1/done0/done1 high at any time, or none.

Test Plan:
- Reset: assert rst mid-EXEC -> immediately all pulses 0, result=0, zero=1, busy=0; after release, IDLE.
- Single add: req0, op0=0, a0=3, b0=4 -> gnt0 next cycle, done0 the cycle after with result=7, zero=0; busy high for 2 cycles.
- Wrap/sub: req1, op1=1, a1=2, b1=5 -> done1 with result=13; then a1=9,b1=9,op1=1 -> result=0, zero=1; add 12+7 -> result=3.
- Round-robin contention: req0 and req1 held high continuously -> grant order 0,1,0,1, each done paired with correct requester and value; FIXED_PRIORITY=1 -> requester 0 served every time while held.
- Operand change after grant: change a0 during EXEC -> result reflects captured value.
- Withdrawn request: req1 pulsed only during requester 0's EXEC/DONE -> never granted, no done1.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-requester controller for a shared 4-bit add/sub ALU.
// Arbitrates, captures the winner's operands, and returns a registered result with a done pulse.
module alu_share_ctrl #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int WIDTH          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             win_q, win_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;

  logic             arb_win;
  logic [WIDTH-1:0] alu_y;

  // On a tie the round-robin pointer names the last winner, so the other side goes next.
  always_comb begin
    arb_win = req1;
    if (req0 && req1) begin
      arb_win = FIXED_PRIORITY ? 1'b0 : ~rr_q;
    end
  end

  assign alu_y = op_q ? (a_q - b_q) : (a_q + b_q);

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          win_d   = arb_win;
          rr_d    = arb_win;
          op_d    = arb_win ? op1 : op0;
          a_d     = arb_win ? a1  : a0;
          b_d     = arb_win ? b1  : b0;
          gnt0_d  = ~arb_win;
          gnt1_d  = arb_win;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_y;
        zero_d   = (alu_y == '0);
        done0_d  = ~win_q;
        done1_d  = win_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b1;
      win_q    <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = busy_q;

endmodule
